// File: rtl/adc_sample_packer.sv
// adc_sample_packer
// Registers the AD9226 sample bus, keeps 1 of every decim+1 samples, packs
// SAMPLES_PER_WORD kept samples (sample 0 in the LSBs) into one FIFO word and
// pulses write_enabled for one cycle per completed word. Words completed while
// the FIFO reports full are counted as dropped. Out-of-range on a kept sample
// is latched for the status path.
// DATA_WIDTH is expected to equal SAMPLE_WIDTH*SAMPLES_PER_WORD, with
// SAMPLES_PER_WORD >= 2.
module adc_sample_packer #(
   parameter int SAMPLE_WIDTH     = 12,
   parameter int SAMPLES_PER_WORD = 4,
   parameter int DATA_WIDTH       = 48,
   parameter int DECIM_WIDTH      = 16,
   parameter int OVF_WIDTH        = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic [SAMPLE_WIDTH-1:0] adc_data,
   input  logic                    adc_otr,
   input  logic [DECIM_WIDTH-1:0]  decim,
   input  logic                    fifo_full,
   input  logic                    clr_status,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    write_enabled,
   output logic [OVF_WIDTH-1:0]    overflow_count,
   output logic                    overflow_sticky,
   output logic                    otr_sticky
);

   localparam int IDX_W = (SAMPLES_PER_WORD > 1) ? $clog2(SAMPLES_PER_WORD) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES_PER_WORD - 1);

   logic [SAMPLE_WIDTH-1:0] adc_q;
   logic                    otr_q;
   logic [DECIM_WIDTH-1:0]  dcnt_q, dcnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [DATA_WIDTH-1:0]   buf_q, buf_d;
   logic [DATA_WIDTH-1:0]   dout_q, dout_d;
   logic                    we_q, we_d;
   logic [OVF_WIDTH-1:0]    ovf_cnt_q, ovf_cnt_d;
   logic                    ovf_stk_q, ovf_stk_d;
   logic                    otr_stk_q, otr_stk_d;
   logic                    accept;

   // Input register: capture the ADC bus on every edge regardless of enable
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         adc_q <= '0;
         otr_q <= 1'b0;
      end else begin
         adc_q <= adc_data;
         otr_q <= adc_otr;
      end
   end

   assign accept = enable && (dcnt_q == '0);

   // Next state: decimation, packing, word completion and status bookkeeping
   always_comb begin
      dcnt_d    = dcnt_q;
      idx_d     = idx_q;
      buf_d     = buf_q;
      dout_d    = dout_q;
      we_d      = 1'b0;
      ovf_cnt_d = ovf_cnt_q;
      ovf_stk_d = ovf_stk_q;
      otr_stk_d = otr_stk_q;

      // Clear first so that a set event on the same edge wins
      if (clr_status) begin
         ovf_cnt_d = '0;
         ovf_stk_d = 1'b0;
         otr_stk_d = 1'b0;
      end

      if (!enable) begin
         // Discard any partial word; the next enabled edge starts at sample 0
         dcnt_d = '0;
         idx_d  = '0;
         buf_d  = '0;
      end else begin
         // >= so that lowering decim mid-run wraps immediately
         dcnt_d = (dcnt_q >= decim) ? '0 : dcnt_q + 1'b1;
         if (accept) begin
            if (otr_q) otr_stk_d = 1'b1;
            if (idx_q == LAST_IDX) begin
               dout_d = {adc_q, buf_q[DATA_WIDTH-SAMPLE_WIDTH-1:0]};
               idx_d  = '0;
               if (fifo_full) begin
                  ovf_stk_d = 1'b1;
                  if (ovf_cnt_d != '1) ovf_cnt_d = ovf_cnt_d + 1'b1;
               end else begin
                  we_d = 1'b1;
               end
            end else begin
               for (int k = 0; k < SAMPLES_PER_WORD - 1; k++)
                  if (idx_q == IDX_W'(k)) buf_d[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = adc_q;
               idx_d = idx_q + 1'b1;
            end
         end
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dcnt_q    <= '0;
         idx_q     <= '0;
         buf_q     <= '0;
         dout_q    <= '0;
         we_q      <= 1'b0;
         ovf_cnt_q <= '0;
         ovf_stk_q <= 1'b0;
         otr_stk_q <= 1'b0;
      end else begin
         dcnt_q    <= dcnt_d;
         idx_q     <= idx_d;
         buf_q     <= buf_d;
         dout_q    <= dout_d;
         we_q      <= we_d;
         ovf_cnt_q <= ovf_cnt_d;
         ovf_stk_q <= ovf_stk_d;
         otr_stk_q <= otr_stk_d;
      end
   end

   assign data_out        = dout_q;
   assign write_enabled   = we_q;
   assign overflow_count  = ovf_cnt_q;
   assign overflow_sticky = ovf_stk_q;
   assign otr_sticky      = otr_stk_q;

endmodule
